dac_tlv5618_cmd_sequencer: RTL and testbench
============================================

# dac_tlv5618_cmd_sequencer

Command sequencer sitting between the USB command decoder and the TLV5618 serial writer in the ECAL DIF. It accepts asynchronous-rate per-channel DAC write requests and coalesces them into one pending slot per channel, where the latest request wins. It then issues them one at a time to the serial writer, holding channel select and code stable for the whole 16-bit shift. It also enforces a guard interval between transfers, because the writer has no busy/ready output.

## Interface
- GUARD_CYCLES, 18, cycles in GUARD after each issue pulse; legal range 17..255.
- Clk  in  1  system clock; the same clock drives the serial writer.
- Rst  in  1  asynchronous, active-high reset.
- Usb_Cmd_En  in  1  single-cycle write request.
- Usb_Cmd_Sel_A_B  in  1  1 = channel A, 0 = channel B; sampled with Usb_Cmd_En.
- Usb_Cmd_Code  in  12  DAC code; sampled with Usb_Cmd_En.
- Dac_Cmd_En  out  1  single-cycle start pulse to the serial writer.
- Dac_Sel_A_B  out  1  channel select to the writer; held from issue through end of GUARD.
- Dac_Code  out  12  code to the writer; held from issue through end of GUARD.
- Busy  out  1  high when state is not IDLE or any pending flag is set.
- Shadow_Code_A  out  12  last code issued to channel A (see Configuration).
- Shadow_Code_B  out  12  last code issued to channel B (see Configuration).

## Operation
- Per-channel storage: Pend_A/Pend_B flag plus 12-bit Req_A/Req_B.
  - Usb_Cmd_En sets the selected flag and overwrites its data.
  - A second request before issue replaces the first, with no queue depth.
- FSM states: IDLE, ISSUE, GUARD.
  - IDLE: if any pend flag is set, select a channel, latch Dac_Sel_A_B/Dac_Code from its Req register, and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE (1 cycle): Dac_Cmd_En=1. Clear the selected pend flag. Load guard counter with GUARD_CYCLES-1. Go to GUARD.
  - GUARD: decrement the counter; at 0 go to IDLE. Dac_Sel_A_B/Dac_Code stay frozen.
- Arbitration: round-robin.
  - Last_Served register resets to B, so A wins the first tie.
  - If only one channel is pending, that channel is selected.
- Simultaneous events:
  - Request for the channel being cleared in ISSUE: the set wins, flag stays 1, new data is stored. Held Dac_Code is unchanged.
  - Requests during GUARD only update Req/Pend. They never alter Dac_Code/Dac_Sel_A_B.
- Reset mid-transfer: all state clears immediately. The writer is reset by the same system reset, so no partial-frame recovery is required.
- Reset values:
  - state IDLE; Dac_Cmd_En 0; Dac_Sel_A_B 0; Dac_Code 0; Busy 0.
  - Shadow_Code_A/B 0; Pend_A/B 0; Req_A/B 0; Last_Served B.

## Timing
- All outputs are registered.
- Request in cycle N with the sequencer idle and nothing pending:
  - pend flag set at edge N+1;
  - ISSUE entered at edge N+2;
  - Dac_Cmd_En high during cycle N+2.
- Dac_Cmd_En width is exactly 1 cycle.
- Issue spacing: consecutive Dac_Cmd_En pulses are exactly GUARD_CYCLES+2 cycles apart when work is pending (ISSUE 1 + GUARD GUARD_CYCLES + IDLE 1). Default is 20 cycles.
- The writer needs 1 + 16 cycles after its start pulse, so GUARD_CYCLES ≥ 17 is mandatory.
- Busy is combinational from registered state and flags. It rises the cycle after the request edge and falls in the IDLE cycle after the final GUARD.

## Configuration
- DAC_SEQ_SHADOW_EN defined:
  - Shadow_Code_A/B load Dac_Code on the ISSUE cycle for the matching channel.
  - They are readable by the USB status path.
- DAC_SEQ_SHADOW_EN undefined:
  - shadow registers are not built;
  - Shadow_Code_A/B are tied to 12'h000;
  - all other behaviour is identical.

## Test plan
- Single write: A, code 12'hABC, in cycle 10 -> Dac_Cmd_En only in cycle 12 with Dac_Sel_A_B=1, Dac_Code=12'hABC held through cycle 30. Busy low from cycle 31.
- Tie: A=12'h111 and B=12'h222 requested in consecutive cycles before the first issue -> A issued first, B issued 20 cycles later. Exactly 2 pulses.
- Coalescing: B=12'h001, 12'h002, 12'h003 requested during an A GUARD -> exactly one B issue, with Dac_Code=12'h003.
- Collision: request A=12'h555 in the same cycle as the ISSUE for A=12'h444 -> 444 is held through GUARD. A second A issue with 555 follows 20 cycles later.
- Reset mid-GUARD: assert Rst in cycle 5 of GUARD with B pending -> all outputs at reset values next cycle. No Dac_Cmd_En after release until a new request arrives.
- Shadow: with DAC_SEQ_SHADOW_EN, write A=12'hFFF then B=12'h7FF -> Shadow_Code_A=12'hFFF and Shadow_Code_B=12'h7FF. Without the macro, both read 0.

Source files
------------

// File: rtl/dac_tlv5618_cmd_sequencer.sv
// dac_tlv5618_cmd_sequencer
// Coalesces per-channel DAC write requests from the USB command decoder into
// one pending slot per channel (latest request wins) and feeds them one at a
// time to the TLV5618 serial writer. Channel select and code stay frozen from
// the issue pulse until the end of the guard interval. The guard interval
// covers the writer's 1 + 16 cycle frame, because the writer has no ready flag.
// Optional feature: define DAC_SEQ_SHADOW_EN to build the per-channel
// shadow registers of the last issued code. Otherwise they read 12'h000.
module dac_tlv5618_cmd_sequencer #(
    parameter int GUARD_CYCLES = 18    // legal range 17..255
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Usb_Cmd_En,
    input  logic        Usb_Cmd_Sel_A_B,
    input  logic [11:0] Usb_Cmd_Code,
    output logic        Dac_Cmd_En,
    output logic        Dac_Sel_A_B,
    output logic [11:0] Dac_Code,
    output logic        Busy,
    output logic [11:0] Shadow_Code_A,
    output logic [11:0] Shadow_Code_B
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    // The counter runs GUARD_CYCLES-1 down to 0, so GUARD lasts GUARD_CYCLES cycles
    localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYCLES - 1);

    // Channel index 1 = A and 0 = B, so a select value indexes the slot directly
    logic [1:0]  pend_reg;
    logic [11:0] req_reg [2];

    state_t      state_reg,   state_next;
    logic [7:0]  guard_reg,   guard_next;
    logic        cmd_en_reg,  cmd_en_next;
    logic        sel_reg,     sel_next;
    logic [11:0] code_reg,    code_next;
    logic        last_reg,    last_next;     // last served channel; 0 = B
    logic        pick_a;                     // arbitration result in IDLE

    // Per-channel pending slot. A new request beats the clear done in ISSUE
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            logic req_hit;
            logic issue_clr;
            assign req_hit   = Usb_Cmd_En && (Usb_Cmd_Sel_A_B == 1'(gi));
            assign issue_clr = (state_reg == ST_ISSUE) && (sel_reg == 1'(gi));

            // Latest request wins; the flag drops only once the channel has been issued
            always_ff @(posedge Clk or posedge Rst) begin
                if (Rst) begin
                    pend_reg[gi] <= 1'b0;
                    req_reg[gi]  <= 12'h000;
                end else if (req_hit) begin
                    pend_reg[gi] <= 1'b1;
                    req_reg[gi]  <= Usb_Cmd_Code;
                end else if (issue_clr) begin
                    pend_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    // State and registered outputs
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_reg  <= ST_IDLE;
            guard_reg  <= 8'd0;
            cmd_en_reg <= 1'b0;
            sel_reg    <= 1'b0;
            code_reg   <= 12'h000;
            last_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            guard_reg  <= guard_next;
            cmd_en_reg <= cmd_en_next;
            sel_reg    <= sel_next;
            code_reg   <= code_next;
            last_reg   <= last_next;
        end
    end

    // Next state, round-robin channel choice and output latching
    always_comb begin
        state_next  = state_reg;
        guard_next  = guard_reg;
        cmd_en_next = 1'b0;
        sel_next    = sel_reg;
        code_next   = code_reg;
        last_next   = last_reg;
        // With both pending, serve the channel that was not served last
        pick_a      = (pend_reg[1] && pend_reg[0]) ? !last_reg : pend_reg[1];

        case (state_reg)
            ST_IDLE: begin
                if (|pend_reg) begin
                    sel_next    = pick_a;
                    code_next   = req_reg[pick_a];
                    last_next   = pick_a;
                    cmd_en_next = 1'b1;     // the pulse coincides with the ISSUE cycle
                    state_next  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                guard_next = GUARD_LOAD;
                state_next = ST_GUARD;
            end
            ST_GUARD: begin
                if (guard_reg == 8'd0) begin
                    state_next = ST_IDLE;
                end else begin
                    guard_next = guard_reg - 8'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign Dac_Cmd_En  = cmd_en_reg;
    assign Dac_Sel_A_B = sel_reg;
    assign Dac_Code    = code_reg;
    assign Busy        = (state_reg != ST_IDLE) || (|pend_reg);

`ifdef DAC_SEQ_SHADOW_EN
    logic [11:0] shadow_reg [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_shadow
            // Record the code actually sent to this channel on its ISSUE cycle
            always_ff @(posedge Clk or posedge Rst) begin
                if (Rst) begin
                    shadow_reg[gi] <= 12'h000;
                end else if ((state_reg == ST_ISSUE) && (sel_reg == 1'(gi))) begin
                    shadow_reg[gi] <= code_reg;
                end
            end
        end
    endgenerate

    assign Shadow_Code_A = shadow_reg[1];
    assign Shadow_Code_B = shadow_reg[0];
`else
    assign Shadow_Code_A = 12'h000;
    assign Shadow_Code_B = 12'h000;
`endif

endmodule

// File: tb/tb_dac_tlv5618_cmd_sequencer.sv
// Testbench for dac_tlv5618_cmd_sequencer: directed scenarios plus random
// requests, checked every cycle against a time-based transaction model.
module tb_dac_tlv5618_cmd_sequencer;

    localparam int G = 18;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Usb_Cmd_En = 1'b0;
    logic        Usb_Cmd_Sel_A_B = 1'b0;
    logic [11:0] Usb_Cmd_Code = 12'h000;
    logic        Dac_Cmd_En;
    logic        Dac_Sel_A_B;
    logic [11:0] Dac_Code;
    logic        Busy;
    logic [11:0] Shadow_Code_A;
    logic [11:0] Shadow_Code_B;

    dac_tlv5618_cmd_sequencer #(.GUARD_CYCLES(G)) dut (
        .Clk             (Clk),
        .Rst             (Rst),
        .Usb_Cmd_En      (Usb_Cmd_En),
        .Usb_Cmd_Sel_A_B (Usb_Cmd_Sel_A_B),
        .Usb_Cmd_Code    (Usb_Cmd_Code),
        .Dac_Cmd_En      (Dac_Cmd_En),
        .Dac_Sel_A_B     (Dac_Sel_A_B),
        .Dac_Code        (Dac_Code),
        .Busy            (Busy),
        .Shadow_Code_A   (Shadow_Code_A),
        .Shadow_Code_B   (Shadow_Code_B)
    );

    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int pulses   = 0;

    // Reference model: pending slots, time of the last issue pulse, held values
    bit          m_pend [2];
    logic [11:0] m_req  [2];
    logic [11:0] m_sh   [2];
    int          last_issue;
    bit          held_sel;
    logic [11:0] held_code;
    bit          last_served;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pend[i] = 1'b0;
            m_req[i]  = 12'h000;
            m_sh[i]   = 12'h000;
        end
        last_issue  = -1000;
        held_sel    = 1'b0;
        held_code   = 12'h000;
        last_served = 1'b0;
    endfunction

    function automatic logic [11:0] exp_shadow(input int ch);
`ifdef DAC_SEQ_SHADOW_EN
        return m_sh[ch];
`else
        return 12'h000;
`endif
    endfunction

    // One clock cycle: check outputs of this cycle, then present this cycle's request
    task automatic step(input bit e, input bit s, input logic [11:0] d);
        bit idle;
        bit pulse_now;
        bit ch;
        @(negedge Clk);
        cyc++;
        // Sequencer is idle once ISSUE (1) plus GUARD (G) cycles have elapsed
        idle      = (cyc - last_issue) >= (G + 1);
        pulse_now = (last_issue == cyc);
        chk("cmd_en", 32'(Dac_Cmd_En), 32'(pulse_now));
        chk("sel",    32'(Dac_Sel_A_B), 32'(held_sel));
        chk("code",   32'(Dac_Code), 32'(held_code));
        chk("busy",   32'(Busy), 32'(!idle || m_pend[0] || m_pend[1]));
        chk("shadow_a", 32'(Shadow_Code_A), 32'(exp_shadow(1)));
        chk("shadow_b", 32'(Shadow_Code_B), 32'(exp_shadow(0)));
        if (Dac_Cmd_En === 1'b1) begin
            pulses++;
            $display("issue cyc=%0d sel=%0d code=%03h", cyc, Dac_Sel_A_B, Dac_Code);
        end

        Usb_Cmd_En      = e;
        Usb_Cmd_Sel_A_B = s;
        Usb_Cmd_Code    = d;

        if (pulse_now) m_sh[held_sel] = held_code;
        if (idle && (m_pend[0] || m_pend[1])) begin
            ch          = (m_pend[1] && m_pend[0]) ? !last_served : m_pend[1];
            held_sel    = ch;
            held_code   = m_req[ch];
            last_served = ch;
            last_issue  = cyc + 1;
        end
        if (pulse_now) m_pend[held_sel] = 1'b0;
        if (e) begin
            m_pend[s] = 1'b1;
            m_req[s]  = d;
        end
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 12'h000);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_en"},   32'(Dac_Cmd_En), 32'd0);
        chk({tag, "_sel"},  32'(Dac_Sel_A_B), 32'd0);
        chk({tag, "_code"}, 32'(Dac_Code), 32'd0);
        chk({tag, "_busy"}, 32'(Busy), 32'd0);
        chk({tag, "_sha"},  32'(Shadow_Code_A), 32'd0);
        chk({tag, "_shb"},  32'(Shadow_Code_B), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst        = 1'b1;
        Usb_Cmd_En = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        @(negedge Clk);
        check_reset_outputs("rst_hold");
        Rst = 1'b0;
        model_reset();
        $display("reset released cyc=%0d", cyc);
    endtask

    int p0;

    initial begin
        model_reset();
        repeat (2) @(negedge Clk);
        check_reset_outputs("por");
        Rst = 1'b0;

        // Single write to A
        p0 = pulses;
        step(1'b1, 1'b1, 12'hABC);
        idle_n(25);
        chk("single_pulses", 32'(pulses - p0), 32'd1);

        // Requests in consecutive cycles: A then B, 20 cycles apart
        p0 = pulses;
        step(1'b1, 1'b1, 12'h111);
        step(1'b1, 1'b0, 12'h222);
        idle_n(45);
        chk("tie_pulses", 32'(pulses - p0), 32'd2);

        // Coalescing: three B writes during an A guard give one B issue
        p0 = pulses;
        step(1'b1, 1'b1, 12'h0AA);
        idle_n(5);
        step(1'b1, 1'b0, 12'h001);
        idle_n(2);
        step(1'b1, 1'b0, 12'h002);
        step(1'b1, 1'b0, 12'h003);
        idle_n(45);
        chk("coalesce_pulses", 32'(pulses - p0), 32'd2);

        // Collision: new A request lands on the ISSUE cycle of the previous A
        p0 = pulses;
        step(1'b1, 1'b1, 12'h444);
        step(1'b0, 1'b0, 12'h000);
        step(1'b1, 1'b1, 12'h555);
        idle_n(45);
        chk("collide_pulses", 32'(pulses - p0), 32'd2);

        // Reset in the fifth GUARD cycle with B pending
        step(1'b1, 1'b1, 12'h321);
        idle_n(2);
        step(1'b1, 1'b0, 12'h654);
        idle_n(3);
        do_reset();
        p0 = pulses;
        idle_n(30);
        chk("post_reset_pulses", 32'(pulses - p0), 32'd0);

        // Shadow contents after A then B
        step(1'b1, 1'b1, 12'hFFF);
        idle_n(22);
        step(1'b1, 1'b0, 12'h7FF);
        idle_n(25);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
                 12'($urandom_range(0, 4095)));
        end
        idle_n(45);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
